tone_meter: RTL and testbench

Synthesizable measurement block for the receive side of the differential tone path. It accepts signed microvolt sample pairs (P and N legs) and forms the differential and common-mode values. Over a fixed power-of-two window it measures differential min/max/peak-to-peak, hysteretic rising zero crossings and the crossing span. Results are presented to the control/CSR logic. It sits downstream of the ADC capture path, or of the tone stimulus in benches, and closes the loop on tone amplitude, frequency and VCM checks.

---
 rtl/tone_meter_pkg.sv | 16 +
 rtl/tone_meter_schmitt.sv | 46 ++++
 rtl/tone_meter.sv | 213 +++++++++++++++++++++
 tb/tb_tone_meter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_meter_pkg.sv
// Shared types and helpers for the differential tone meter.
package tone_meter_pkg;

    localparam int unsigned TM_UV_W = 32;

    typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StDone} tm_state_t;

    // Clamp a 33-bit signed value into the signed 32-bit range.
    function automatic logic [TM_UV_W-1:0] sat33to32(input logic [TM_UV_W:0] x);
        if (x[TM_UV_W] != x[TM_UV_W-1]) begin
            return x[TM_UV_W] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        return x[TM_UV_W-1:0];
    endfunction

endpackage

// File: rtl/tone_meter_schmitt.sv
// Hysteretic zero-crossing detector; rise_o strobes on an accepted LOW->HIGH transition.
module tone_meter_schmitt
    import tone_meter_pkg::*;
#(
    parameter int unsigned HYST_UV = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    input  logic               init_i,
    input  logic [TM_UV_W-1:0] diff_i,
    output logic               rise_o
);

    localparam logic signed [TM_UV_W-1:0] HystPos = TM_UV_W'(HYST_UV);
    localparam logic signed [TM_UV_W-1:0] HystNeg = -HystPos;

    logic high_q, high_d;
    logic signed [TM_UV_W-1:0] diff_s;

    assign diff_s = diff_i;

    always_comb begin
        high_d = high_q;
        rise_o = 1'b0;
        if (valid_i) begin
            if (init_i) begin
                high_d = ~diff_s[TM_UV_W-1];
            end else if (!high_q && diff_s >= HystPos) begin
                high_d = 1'b1;
                rise_o = 1'b1;
            end else if (high_q && diff_s <= HystNeg) begin
                high_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_q <= 1'b0;
        end else begin
            high_q <= high_d;
        end
    end

endmodule

// File: rtl/tone_meter.sv
// Windowed differential min/max/pp, rising-crossing count and span meter.
// Define TONE_METER_CM_EN to build the common-mode average accumulator.
module tone_meter
    import tone_meter_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2    = 10,
    parameter int unsigned SETTLE_SAMPLES = 64,
    parameter int unsigned HYST_UV        = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [TM_UV_W-1:0]     sig_p_uv,
    input  logic [TM_UV_W-1:0]     sig_n_uv,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [TM_UV_W-1:0]     dm_max_uv,
    output logic [TM_UV_W-1:0]     dm_min_uv,
    output logic [TM_UV_W-1:0]     dm_pp_uv,
    output logic [WINDOW_LOG2:0]   crossings,
    output logic [WINDOW_LOG2:0]   span_samples,
    output logic [TM_UV_W-1:0]     cm_avg_uv
);

    localparam int unsigned IdxW = WINDOW_LOG2;
    localparam int unsigned CntW = WINDOW_LOG2 + 1;

    tm_state_t       state_q, state_d;
    logic [31:0]     settle_q, settle_d;
    logic [IdxW-1:0] idx_q, idx_d;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    settle_d = '0;
                    idx_d    = '0;
                    state_d  = (SETTLE_SAMPLES == 0) ? StMeasure : StSettle;
                end
            end
            StSettle: begin
                if (in_valid) begin
                    settle_d = settle_q + 32'd1;
                    if (settle_q == SETTLE_SAMPLES - 1) state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (in_valid) begin
                    idx_d = idx_q + 1'b1;
                    if (&idx_q) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Input stage: diff/sum are registered before compare and accumulate.
    logic [TM_UV_W:0]   diff_w;
    logic               s_valid_q, s_init_q;
    logic [IdxW-1:0]    s_idx_q;
    logic [TM_UV_W-1:0] s_diff_q;

    assign diff_w = {sig_p_uv[TM_UV_W-1], sig_p_uv} - {sig_n_uv[TM_UV_W-1], sig_n_uv};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            settle_q  <= '0;
            idx_q     <= '0;
            s_valid_q <= 1'b0;
            s_init_q  <= 1'b0;
            s_idx_q   <= '0;
            s_diff_q  <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            idx_q     <= idx_d;
            s_valid_q <= in_valid && (state_q == StMeasure);
            s_init_q  <= (idx_q == '0);
            s_idx_q   <= idx_q;
            if (in_valid) s_diff_q <= sat33to32(diff_w);
        end
    end

    logic rise;

    tone_meter_schmitt #(
        .HYST_UV (HYST_UV)
    ) u_schmitt (
        .clk     (clk),
        .reset   (reset),
        .valid_i (s_valid_q),
        .init_i  (s_init_q),
        .diff_i  (s_diff_q),
        .rise_o  (rise)
    );

    logic signed [TM_UV_W-1:0] max_q, max_d, min_q, min_d, diff_s;
    logic [CntW-1:0]           cross_q, cross_d;
    logic [IdxW-1:0]           first_q, first_d, last_q, last_d;
    logic                      have_first_q, have_first_d;

    assign diff_s = s_diff_q;

    always_comb begin
        max_d        = max_q;
        min_d        = min_q;
        cross_d      = cross_q;
        first_d      = first_q;
        last_d       = last_q;
        have_first_d = have_first_q;
        if (s_valid_q) begin
            if (s_init_q) begin
                max_d        = diff_s;
                min_d        = diff_s;
                cross_d      = '0;
                first_d      = '0;
                last_d       = '0;
                have_first_d = 1'b0;
            end else begin
                if (diff_s > max_q) max_d = diff_s;
                if (diff_s < min_q) min_d = diff_s;
                if (rise) begin
                    cross_d = cross_q + 1'b1;
                    last_d  = s_idx_q;
                    if (!have_first_q) begin
                        first_d      = s_idx_q;
                        have_first_d = 1'b1;
                    end
                end
            end
        end
    end

    // Outputs latch the next-state values so the final sample is included.
    logic [TM_UV_W:0] pp_w;
    logic [IdxW-1:0]  span_w;

    assign pp_w   = {max_d[TM_UV_W-1], max_d} - {min_d[TM_UV_W-1], min_d};
    assign span_w = last_d - first_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_q        <= '0;
            min_q        <= '0;
            cross_q      <= '0;
            first_q      <= '0;
            last_q       <= '0;
            have_first_q <= 1'b0;
            done         <= 1'b0;
            dm_max_uv    <= '0;
            dm_min_uv    <= '0;
            dm_pp_uv     <= '0;
            crossings    <= '0;
            span_samples <= '0;
        end else begin
            max_q        <= max_d;
            min_q        <= min_d;
            cross_q      <= cross_d;
            first_q      <= first_d;
            last_q       <= last_d;
            have_first_q <= have_first_d;
            done         <= (state_q == StDone);
            if (state_q == StDone) begin
                dm_max_uv    <= max_d;
                dm_min_uv    <= min_d;
                dm_pp_uv     <= pp_w[TM_UV_W] ? '1 : pp_w[TM_UV_W-1:0];
                crossings    <= cross_d;
                span_samples <= (cross_d >= CntW'(2)) ? {1'b0, span_w} : '0;
            end
        end
    end

    assign busy = (state_q != StIdle);

`ifdef TONE_METER_CM_EN
    localparam int unsigned AccW = TM_UV_W + 1 + WINDOW_LOG2;

    logic [TM_UV_W:0]        sum_w, s_sum_q;
    logic signed [AccW-1:0]  acc_q, acc_d, sum_ext;
    logic [TM_UV_W-1:0]      cm_q;

    assign sum_w   = {sig_p_uv[TM_UV_W-1], sig_p_uv} + {sig_n_uv[TM_UV_W-1], sig_n_uv};
    assign sum_ext = {{WINDOW_LOG2{s_sum_q[TM_UV_W]}}, s_sum_q};

    always_comb begin
        acc_d = acc_q;
        if (s_valid_q) acc_d = s_init_q ? sum_ext : acc_q + sum_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_sum_q <= '0;
            acc_q   <= '0;
            cm_q    <= '0;
        end else begin
            if (in_valid) s_sum_q <= sum_w;
            acc_q <= acc_d;
            if (state_q == StDone) cm_q <= TM_UV_W'(acc_d >>> (WINDOW_LOG2 + 1));
        end
    end

    assign cm_avg_uv = cm_q;
`else
    assign cm_avg_uv = '0;
`endif

endmodule

// File: tb/tb_tone_meter.sv
// Scoreboard bench: two tone_meter instances (different settle/hysteresis) share one stimulus.
module tb_tone_meter;

    localparam int W   = 8;
    localparam int N   = 1 << W;
    localparam int SB  = 3;
    localparam int H   = 1000;
    localparam int TOT = N + SB;

    typedef struct {
        longint mx;
        longint mn;
        longint pp;
        longint cr;
        longint sp;
        longint cm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, start;
    logic [31:0] p, n;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] max_a, min_a, pp_a, cm_a, max_b, min_b, pp_b, cm_b;
    logic [W:0]  cr_a, sp_a, cr_b, sp_b;

    int     checks = 0;
    int     errors = 0;
    int     ndone_a = 0;
    int     ndone_b = 0;
    time    t_last, t_done_a;
    int     p_arr[TOT];
    int     n_arr[TOT];
    exp_t   qa[$];
    exp_t   qb[$];
    longint cm_exp;

    always #5 clk = ~clk;

    tone_meter #(.WINDOW_LOG2(W), .SETTLE_SAMPLES(0), .HYST_UV(H)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sig_p_uv(p), .sig_n_uv(n),
        .start(start), .busy(busy_a), .done(done_a), .dm_max_uv(max_a), .dm_min_uv(min_a),
        .dm_pp_uv(pp_a), .crossings(cr_a), .span_samples(sp_a), .cm_avg_uv(cm_a)
    );

    tone_meter #(.WINDOW_LOG2(W), .SETTLE_SAMPLES(SB), .HYST_UV(0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sig_p_uv(p), .sig_n_uv(n),
        .start(start), .busy(busy_b), .done(done_b), .dm_max_uv(max_b), .dm_min_uv(min_b),
        .dm_pp_uv(pp_b), .crossings(cr_b), .span_samples(sp_b), .cm_avg_uv(cm_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int s0, input longint hyst);
        exp_t   e;
        longint d, mx, mn, sum;
        bit     high;
        int     cnt, first, last;
        mx = 0; mn = 0; sum = 0; high = 0; cnt = 0; first = 0; last = 0;
        for (int i = 0; i < N; i++) begin
            d = longint'(p_arr[s0+i]) - longint'(n_arr[s0+i]);
            if (d > 64'sd2147483647) d = 64'sd2147483647;
            if (d < -64'sd2147483648) d = -64'sd2147483648;
            sum += longint'(p_arr[s0+i]) + longint'(n_arr[s0+i]);
            if (i == 0) begin
                mx = d; mn = d; high = (d >= 0);
            end else begin
                if (d > mx) mx = d;
                if (d < mn) mn = d;
                if (!high && d >= hyst) begin
                    high = 1; cnt++; last = i;
                    if (cnt == 1) first = i;
                end else if (high && d <= -hyst) begin
                    high = 0;
                end
            end
        end
        e.mx = mx; e.mn = mn;
        e.pp = (mx - mn > 64'sd4294967295) ? 64'sd4294967295 : mx - mn;
        e.cr = cnt;
        e.sp = (cnt >= 2) ? last - first : 0;
`ifdef TONE_METER_CM_EN
        e.cm = sum >>> (W + 1);
`else
        e.cm = 0;
`endif
        return e;
    endfunction

    task automatic cmp_out(input string who, input exp_t e, input logic [31:0] mx,
                           input logic [31:0] mn, input logic [31:0] pp, input logic [31:0] cm,
                           input logic [W:0] cr, input logic [W:0] sp);
        check({who, "_max"}, longint'($signed(mx)), e.mx);
        check({who, "_min"}, longint'($signed(mn)), e.mn);
        check({who, "_pp"}, longint'(pp), e.pp);
        check({who, "_cross"}, longint'(cr), e.cr);
        check({who, "_span"}, longint'(sp), e.sp);
        check({who, "_cm"}, longint'($signed(cm)), e.cm);
    endtask

    always @(negedge clk) begin
        if (done_a) begin
            ndone_a++;
            t_done_a = $time;
            check("a_busy_at_done", longint'(busy_a), 0);
            if (qa.size() == 0) check("a_unexpected_done", 1, 0);
            else cmp_out("a", qa.pop_front(), max_a, min_a, pp_a, cm_a, cr_a, sp_a);
        end
        if (done_b) begin
            ndone_b++;
            if (qb.size() == 0) check("b_unexpected_done", 1, 0);
            else cmp_out("b", qb.pop_front(), max_b, min_b, pp_b, cm_b, cr_b, sp_b);
        end
    end

    task automatic fill(input int kind);
        int  d;
        real ang;
        for (int k = 0; k < TOT; k++) begin
            case (kind)
                0: begin
                    p_arr[k] = (((k / 8) % 2) == 0) ? 500000 : -500000;
                    n_arr[k] = -p_arr[k];
                end
                1: begin
                    p_arr[k] = 1250000;
                    n_arr[k] = 1250000;
                end
                2: begin
                    ang = 6.283185307179586 * (real'(k) + 0.5) / 10.0;
                    d = $rtoi(2000000.0 * $sin(ang) + ((ang < 0.0) ? 0.0 : 0.0));
                    p_arr[k] = d + 100000;
                    n_arr[k] = 100000;
                end
                3: begin
                    p_arr[k] = int'($urandom_range(1600, 0)) - 800;
                    n_arr[k] = 0;
                end
                default: begin
                    p_arr[k] = ((k % 2) == 0) ? 32'sh7FFF_0000 : -32'sh7FFF_0000;
                    n_arr[k] = -p_arr[k];
                end
            endcase
        end
    endtask

    task automatic wait_done(input int da, input int db);
        for (int c = 0; c < 3000 && (ndone_a < da || ndone_b < db); c++) @(negedge clk);
        if (ndone_a < da || ndone_b < db) check("done_timeout", 0, 1);
    endtask

    task automatic run_window(input int kind, input bit gaps, input bit poke);
        int da0, db0;
        fill(kind);
        qa.push_back(model(0, H));
        qb.push_back(model(SB, 0));
        da0 = ndone_a;
        db0 = ndone_b;
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", longint'(busy_a), 1);
        for (int k = 0; k < TOT; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                p = $urandom;
                n = $urandom;
                @(negedge clk);
            end
            in_valid = 1'b1;
            p = p_arr[k];
            n = n_arr[k];
            start = poke && (k == 100);
            if (k == N - 1) t_last = $time;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        wait_done(da0 + 1, db0 + 1);
        check("done_latency_a", longint'((t_done_a - t_last) / 10), 2);
        repeat (4) @(negedge clk);
        check("single_done_a", ndone_a, da0 + 1);
        check("single_done_b", ndone_b, db0 + 1);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        p = '0;
        n = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", longint'(busy_a), 0);
        check("rst_done", longint'(done_a), 0);
        check("rst_max", longint'(max_a), 0);
        check("rst_pp", longint'(pp_a), 0);
        check("rst_cross", longint'(cr_a), 0);
        check("rst_cm", longint'(cm_a), 0);
        reset = 1'b0;
        @(negedge clk);

        run_window(0, 1'b0, 1'b0);
        check("sq_max", longint'($signed(max_a)), 1000000);
        check("sq_min", longint'($signed(min_a)), -1000000);
        check("sq_pp", longint'(pp_a), 2000000);
        check("sq_cross", longint'(cr_a), 15);
        check("sq_span", longint'(sp_a), 224);

        run_window(1, 1'b1, 1'b0);
        check("const_pp", longint'(pp_a), 0);
        check("const_cross", longint'(cr_a), 0);
`ifdef TONE_METER_CM_EN
        cm_exp = 1250000;
`else
        cm_exp = 0;
`endif
        check("const_cm", longint'($signed(cm_a)), cm_exp);

        run_window(2, 1'b0, 1'b1);
        check("sine_pp_near", longint'(pp_a >= 32'd3960000 && pp_a <= 32'd4040000), 1);
        check("sine_cross_near", longint'(cr_a >= 24 && cr_a <= 26), 1);

        run_window(3, 1'b0, 1'b0);
        check("noise_cross_hyst", longint'(cr_a), 0);
        check("noise_cross_nohyst", longint'(cr_b > 0), 1);

        run_window(4, 1'b0, 1'b0);
        check("sat_max", longint'(max_a), 64'h7FFF_FFFF);
        check("sat_pp", longint'(pp_a), 64'hFFFF_FFFF);

        // Abort a measurement partway through the window.
        begin
            int da0;
            fill(0);
            da0 = ndone_a;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 100; k++) begin
                in_valid = 1'b1;
                p = p_arr[k];
                n = n_arr[k];
                @(negedge clk);
            end
            reset = 1'b1;
            #1;
            check("abort_busy", longint'(busy_a), 0);
            check("abort_max", longint'(max_a), 0);
            check("abort_pp", longint'(pp_a), 0);
            check("abort_cross", longint'(cr_a), 0);
            @(negedge clk);
            reset = 1'b0;
            in_valid = 1'b0;
            repeat (300) @(negedge clk);
            check("abort_no_done", ndone_a, da0);
        end

        run_window(0, 1'b1, 1'b0);
        check("rerun_cross", longint'(cr_a), 15);
        check("rerun_span", longint'(sp_a), 224);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
